// File: rtl/ddp_pkg.sv
// DDP packet layout and transmitter state encoding
// shared by the clocked injector and its interface.
package ddp_pkg;

  localparam int PKT_W   = 38;
  localparam int DEST_W  = 3;
  localparam int GEN_W   = 8;
  localparam int NODE_W  = 7;
  localparam int FLAGS_W = 4;
  localparam int DATA_W  = 16;

  localparam int DATA_LSB  = 0;
  localparam int FLAGS_LSB = DATA_LSB + DATA_W;
  localparam int NODE_LSB  = FLAGS_LSB + FLAGS_W;
  localparam int GEN_LSB   = NODE_LSB + NODE_W;
  localparam int DEST_LSB  = GEN_LSB + GEN_W;

  typedef struct packed {
    logic [DEST_W-1:0]  dest;
    logic [GEN_W-1:0]   gen;
    logic [NODE_W-1:0]  node;
    logic [FLAGS_W-1:0] flags;
    logic [DATA_W-1:0]  data;
  } ddp_pkt_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_LO,
    WAIT_HI
  } tx_state_t;

endpackage

// File: rtl/ddp_pkt_tx_if.sv
// Push-side valid/ready bundle of the DDP packet
// transmitter.
interface ddp_pkt_tx_if;
  import ddp_pkg::*;

  logic     in_valid;
  logic     in_ready;
  ddp_pkt_t in_pkt;

  modport master (
    output in_valid,
    output in_pkt,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_pkt,
    output in_ready
  );

endinterface

// File: rtl/ddp_sync2.sv
// Two-flop synchronizer with a parameterized
// reset value for idle-high async handshakes.
module ddp_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ddp_pkt_tx.sv
// Clocked DDP packet injector: FIFO + Send/Ack launcher.
// Optional ack timeout under DDP_TX_TIMEOUT_EN.
module ddp_pkt_tx
  import ddp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PULSE_W = 2,
  parameter int TMO_CYC = 1024
) (
  input  logic         CLK,
  input  logic         MR,
  ddp_pkt_tx_if.slave  src,
  output logic         Send_out,
  input  logic         Ack_in,
  output ddp_pkt_t     PACKET_OUT,
  output logic         busy,
  output logic         tmo_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(PULSE_W + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      PULSE_W < 1 || TMO_CYC < 1) begin : g_bad_cfg
    $error("ddp_pkt_tx: illegal parameters");
  end

  tx_state_t     state;
  logic [CW-1:0] cnt;
  logic          ack_s;
  ddp_pkt_t      mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          tmo_hit;

  ddp_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (CLK),
    .rst (MR),
    .d   (Ack_in),
    .q   (ack_s)
  );

  assign full         = (count == (AW+1)'(DEPTH));
  assign empty        = (count == '0);
  assign src.in_ready = !full;
  assign push         = src.in_valid && !full;
  assign pop          = (state == IDLE) && !empty && ack_s;
  assign busy         = (state != IDLE) || !empty;

  always_ff @(posedge CLK) begin
    if (push) mem[wp] <= src.in_pkt;
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef DDP_TX_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          waiting;
  logic          err_q;

  // counts only cycles spent waiting without a state change
  assign waiting = (state == WAIT_LO && ack_s) ||
                   (state == WAIT_HI && !ack_s);
  assign tmo_hit = waiting && (tmo_cnt == TW'(TMO_CYC - 1));
  assign tmo_err = err_q;

  always_ff @(posedge CLK) begin
    if (MR) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (waiting && !tmo_hit) ? tmo_cnt + 1'b1 : '0;
      if (tmo_hit) err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo_err = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (MR) begin
      state      <= IDLE;
      Send_out   <= 1'b1;
      PACKET_OUT <= '0;
      cnt        <= '0;
    end else if (tmo_hit) begin
      state    <= IDLE;
      Send_out <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            PACKET_OUT <= mem[rp];
            cnt        <= CW'(PULSE_W - 1);
            Send_out   <= 1'b0;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (cnt == '0) begin
            Send_out <= 1'b1;
            state    <= WAIT_LO;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_LO: if (!ack_s) state <= WAIT_HI;
        WAIT_HI: if (ack_s)  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddp_pkt_tx.sv
// Directed self-checking bench for ddp_pkt_tx with a
// delayed-ack responder and a Send_out pulse monitor.
module tb_ddp_pkt_tx;

  localparam int DEPTH   = 4;
  localparam int PULSE_W = 2;
  localparam int TMO_CYC = 16;

  logic        CLK = 1'b0;
  logic        MR  = 1'b1;
  logic        Send_out;
  logic        Ack_in;
  logic [37:0] pkt_out;
  logic        busy;
  logic        tmo_err;

  logic resp_ack   = 1'b1;
  logic hold_lo    = 1'b0;
  logic resp_en    = 1'b1;
  logic chk_stable = 1'b1;

  int checks     = 0;
  int fails      = 0;
  int launches   = 0;
  int stable_err = 0;

  logic [37:0] got[$];
  int          pw[$];
  logic [37:0] exp_q[$];

  ddp_pkt_tx_if bus ();

  assign Ack_in = resp_ack & ~hold_lo;

  ddp_pkt_tx #(
    .DEPTH   (DEPTH),
    .PULSE_W (PULSE_W),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .CLK        (CLK),
    .MR         (MR),
    .src        (bus.slave),
    .Send_out   (Send_out),
    .Ack_in     (Ack_in),
    .PACKET_OUT (pkt_out),
    .busy       (busy),
    .tmo_err    (tmo_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [37:0] obs,
                     input logic [37:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    chk(tag, {37'd0, busy}, 38'd0);
  endtask

  // Responder: ack 3 cycles after Send_out falls, for 4 cycles
  initial begin
    logic [37:0] cap;
    forever begin
      @(negedge Send_out);
      if (resp_en && !MR) begin
        repeat (3) @(posedge CLK);
        #2;
        resp_ack = 1'b0;
        cap = pkt_out;
        got.push_back(pkt_out);
        repeat (4) @(posedge CLK);
        #1;
        if (chk_stable && pkt_out !== cap) stable_err++;
        #1;
        resp_ack = 1'b1;
      end
    end
  end

  // Pulse monitor: width in cycles of each Send_out low pulse
  initial begin
    int w;
    forever begin
      @(negedge Send_out);
      if (!MR) begin
        launches++;
        w = 0;
        do begin
          @(posedge CLK);
          #1;
          w++;
        end while (!Send_out && w < 100);
        pw.push_back(w);
      end
    end
  end

  initial begin
    logic [37:0] p1;
    logic [37:0] p;
    int n;

    bus.in_valid = 1'b0;
    bus.in_pkt   = '0;
    p1 = {3'b111, 8'd0, 7'd1, 4'b0, 16'd4};

    // reset
    repeat (5) tick();
    chk("rst_send", {37'd0, Send_out}, 38'd1);
    chk("rst_ready", {37'd0, bus.in_ready}, 38'd1);
    chk("rst_busy", {37'd0, busy}, 38'd0);
    chk("rst_pkt", pkt_out, 38'd0);
    chk("rst_tmo", {37'd0, tmo_err}, 38'd0);
    MR = 1'b0;
    tick();

    // single packet, 2-cycle push-to-launch latency
    bus.in_valid = 1'b1;
    bus.in_pkt   = p1;
    exp_q.push_back(p1);
    tick();
    bus.in_valid = 1'b0;
    chk("p1_nolaunch", {37'd0, Send_out}, 38'd1);
    chk("p1_busy", {37'd0, busy}, 38'd1);
    tick();
    chk("p1_launch", {37'd0, Send_out}, 38'd0);
    chk("p1_pkt", pkt_out, p1);
    wait_idle("p1_idle", 50);
    chk("p1_launches", 38'(launches), 38'd1);

    // fill FIFO while downstream holds Ack low
    hold_lo = 1'b1;
    repeat (3) tick();
    for (int i = 1; i <= 4; i++) begin
      p = {3'(i), 8'(i * 3), 7'd2, 4'hA, 16'(i)};
      exp_q.push_back(p);
      chk("fill_ready", {37'd0, bus.in_ready}, 38'd1);
      bus.in_valid = 1'b1;
      bus.in_pkt   = p;
      tick();
    end
    chk("full_ready", {37'd0, bus.in_ready}, 38'd0);
    p = {3'd5, 8'd15, 7'd2, 4'hA, 16'd5};
    exp_q.push_back(p);
    bus.in_pkt = p;
    repeat (3) tick();
    chk("hold_nolaunch", {37'd0, Send_out}, 38'd1);
    chk("hold_ready", {37'd0, bus.in_ready}, 38'd0);

    // release Ack: launch after the synchronizer delay
    hold_lo = 1'b0;
    tick();
    tick();
    chk("rel_wait", {37'd0, Send_out}, 38'd1);
    tick();
    chk("rel_launch", {37'd0, Send_out}, 38'd0);
    chk("rel_ready", {37'd0, bus.in_ready}, 38'd1);
    tick();
    bus.in_valid = 1'b0;
    wait_idle("burst_idle", 300);
    chk("burst_launches", 38'(launches), 38'd6);
    chk("burst_count", 38'(got.size()), 38'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size())
        chk("order", got[i], exp_q[i]);
    end

    // reset during WAIT_HI with two packets queued
    for (int i = 0; i < 3; i++) begin
      p = {3'd6, 8'd0, 7'd3, 4'h1, 16'(16'h100 + i)};
      if (i == 0) exp_q.push_back(p);
      bus.in_valid = 1'b1;
      bus.in_pkt   = p;
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (5) tick();
    chk("wh_busy", {37'd0, busy}, 38'd1);
    chk("wh_send", {37'd0, Send_out}, 38'd1);
    chk_stable = 1'b0;
    MR = 1'b1;
    tick();
    chk("mr_send", {37'd0, Send_out}, 38'd1);
    chk("mr_busy", {37'd0, busy}, 38'd0);
    chk("mr_ready", {37'd0, bus.in_ready}, 38'd1);
    chk("mr_pkt", pkt_out, 38'd0);
    MR = 1'b0;
    repeat (30) tick();
    chk_stable = 1'b1;
    chk("mr_launches", 38'(launches), 38'd7);
    chk("mr_got", 38'(got.size()), 38'd7);
    if (got.size() == 7)
      chk("mr_lastpkt", got[6], exp_q[6]);
    chk("mr_send_idle", {37'd0, Send_out}, 38'd1);

    for (int i = 0; i < pw.size(); i++)
      chk("pulse_w", 38'(pw[i]), 38'(PULSE_W));
    chk("stable", 38'(stable_err), 38'd0);

`ifdef DDP_TX_TIMEOUT_EN
    // responder silent: timeout drops the packet, next one launches
    resp_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pkt   = {3'd1, 8'd1, 7'd1, 4'h2, 16'(16'h200 + i)};
      tick();
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (!tmo_err && n < 60) begin
      tick();
      n++;
    end
    chk("tmo_set", {37'd0, tmo_err}, 38'd1);
    chk("tmo_send", {37'd0, Send_out}, 38'd1);
    n = 0;
    while (launches < 9 && n < 5) begin
      tick();
      n++;
    end
    chk("tmo_next", 38'(launches), 38'd9);
    chk("tmo_pkt", pkt_out, {3'd1, 8'd1, 7'd1, 4'h2, 16'h201});
    repeat (3) tick();
    chk("tmo_sticky", {37'd0, tmo_err}, 38'd1);
`else
    chk("tmo_off", {37'd0, tmo_err}, 38'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
